// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: sequencer state encoding and sizing helper shared by the filter_ctrl slice
package filter_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int n = v - 1; n > 0; n = n >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/filter_ctrl_if.sv
// filter_ctrl_if: host kernel/image streams and filter-side config/image/result signals
interface filter_ctrl_if #(
  parameter int HEIGHT_NB = 3,
  parameter int IMG_WIDTH = 8,
  parameter int KER_WIDTH = 16
);
  logic                           load_start;
  logic [KER_WIDTH-1:0]           ker_data;
  logic                           ker_val;
  logic                           ker_rdy;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] img_data;
  logic                           img_val;
  logic                           img_rdy;
  logic [KER_WIDTH-1:0]           cfg_ker;
  logic                           cfg_val;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] flt_img;
  logic                           flt_val;
  logic                           flt_res_val;
  logic                           loaded;
  logic                           busy;
  logic                           err;
  modport slave (
    input  load_start, ker_data, ker_val, img_data, img_val, flt_res_val,
    output ker_rdy, img_rdy, cfg_ker, cfg_val, flt_img, flt_val, loaded, busy, err
  );
  modport master (
    output load_start, ker_data, ker_val, img_data, img_val, flt_res_val,
    input  ker_rdy, img_rdy, cfg_ker, cfg_val, flt_img, flt_val, loaded, busy, err
  );
endinterface

// File: rtl/filter_ctrl_flight_counter.sv
// flight_counter: in-flight result tracker with a sticky flag for results that nothing issued
module flight_counter import filter_ctrl_pkg::*; #(
  parameter int MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc,
  input  logic                      dec,
  output logic [clog2(MAX+1)-1:0]   count,
  output logic                      err
);
  localparam int CW = clog2(MAX + 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      err   <= 1'b0;
    end else if (inc && !dec) begin
      if (count != CW'(MAX)) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count == '0) err <= 1'b1;
      else count <= count - 1'b1;
    end
endmodule

// File: rtl/filter_ctrl.sv
// filter_ctrl: loads exactly MAC_NB kernel words into the filter, gates the image stream,
// and drains in-flight results before any reload so kernels never mix
module filter_ctrl import filter_ctrl_pkg::*; #(
  parameter int HEIGHT_NB    = 3,
  parameter int WIDTH_NB     = 3,
  parameter int IMG_WIDTH    = 8,
  parameter int KER_WIDTH    = 16,
  parameter int MAC_PIPELINE = 5
) (
  input logic clk,
  input logic rst_n,
  filter_ctrl_if.slave bus
);
  localparam int MAC_NB     = HEIGHT_NB * WIDTH_NB;
  localparam int FLIGHT_MAX = MAC_PIPELINE * WIDTH_NB;
  localparam int KCW        = clog2(MAC_NB + 1);
  localparam int FCW        = clog2(FLIGHT_MAX + 1);
  state_t                         state, next;
  logic                           pending;
  logic [KCW-1:0]                 ker_cnt;
  logic [FCW-1:0]                 inflight;
  logic [KER_WIDTH-1:0]           cfg_ker_q;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] flt_img_q;
  logic                           cfg_val_q, flt_val_q, loaded_q;
  logic                           ker_acc, img_acc, last_word, enter_load;
  assign bus.ker_rdy = state == LOAD;
  assign bus.img_rdy = state == RUN && !pending;
  assign bus.busy    = state == LOAD || state == DRAIN;
  assign bus.cfg_ker = cfg_ker_q;
  assign bus.cfg_val = cfg_val_q;
  assign bus.flt_img = flt_img_q;
  assign bus.flt_val = flt_val_q;
  assign bus.loaded  = loaded_q;
  assign ker_acc     = bus.ker_val && bus.ker_rdy;
  assign img_acc     = bus.img_val && bus.img_rdy;
  assign last_word   = ker_acc && ker_cnt == KCW'(MAC_NB - 1);
  assign enter_load  = next == LOAD && state != LOAD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = (state == IDLE  && bus.load_start) ? LOAD  :
           (state == LOAD  && last_word)      ? RUN   :
           (state == RUN   && pending)        ? DRAIN :
           (state == DRAIN && inflight == '0) ? LOAD  : state;
  end
  // a RUN-state load request is held one cycle so img_rdy drops before DRAIN begins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending   <= 1'b0;
      ker_cnt   <= '0;
      loaded_q  <= 1'b0;
      cfg_ker_q <= '0;
      cfg_val_q <= 1'b0;
      flt_img_q <= '0;
      flt_val_q <= 1'b0;
    end else begin
      pending   <= state == RUN && !pending && bus.load_start;
      ker_cnt   <= enter_load ? '0 : ker_acc ? ker_cnt + 1'b1 : ker_cnt;
      loaded_q  <= enter_load ? 1'b0 : last_word ? 1'b1 : loaded_q;
      cfg_val_q <= ker_acc;
      flt_val_q <= img_acc;
      if (ker_acc) cfg_ker_q <= bus.ker_data;
      if (img_acc) flt_img_q <= bus.img_data;
    end
  flight_counter #(.MAX(FLIGHT_MAX)) u_flight (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flt_val_q),
    .dec   (bus.flt_res_val),
    .count (inflight),
    .err   (bus.err)
  );
endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: scenario tasks over a cycle-stepping scoreboard for cfg/flt outputs and err
module tb_filter_ctrl;
  localparam int HN = 3, WN = 3, IW = 8, KW = 16, MP = 5, LAT = 12;
  logic clk, rst_n;
  int n_cmp = 0, n_bad = 0;
  logic [KW-1:0] ker_q[$];
  logic [HN*IW-1:0] img_q[$];
  int m = 0;
  bit err_exp = 0, auto_res = 0;
  logic [LAT-1:0] pipe = '0;
  filter_ctrl_if #(.HEIGHT_NB(HN), .IMG_WIDTH(IW), .KER_WIDTH(KW)) bus ();
  filter_ctrl #(.HEIGHT_NB(HN), .WIDTH_NB(WN), .IMG_WIDTH(IW), .KER_WIDTH(KW), .MAC_PIPELINE(MP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end
  task automatic tick();
    bit ka, ia, fv, fr;
    logic [KW-1:0] ek;
    logic [HN*IW-1:0] ei;
    ka = bus.ker_val && bus.ker_rdy;
    ia = bus.img_val && bus.img_rdy;
    fv = bus.flt_val;
    fr = bus.flt_res_val;
    if (ka) ker_q.push_back(bus.ker_data);
    if (ia) img_q.push_back(bus.img_data);
    @(posedge clk);
    #1;
    if (fv && !fr) m++;
    else if (fr && !fv) begin
      if (m == 0) err_exp = 1;
      else m--;
    end
    n_cmp++;
    if (bus.cfg_val !== ka) begin
      n_bad++;
      $display("FAIL cfg_val: got %b, expected %b", bus.cfg_val, ka);
    end
    if (bus.cfg_val === 1'b1 && ker_q.size() > 0) begin
      ek = ker_q.pop_front();
      n_cmp++;
      if (bus.cfg_ker !== ek) begin
        n_bad++;
        $display("FAIL cfg_ker: got %0d, expected %0d", bus.cfg_ker, ek);
      end
    end
    n_cmp++;
    if (bus.flt_val !== ia) begin
      n_bad++;
      $display("FAIL flt_val: got %b, expected %b", bus.flt_val, ia);
    end
    if (bus.flt_val === 1'b1 && img_q.size() > 0) begin
      ei = img_q.pop_front();
      n_cmp++;
      if (bus.flt_img !== ei) begin
        n_bad++;
        $display("FAIL flt_img: got %h, expected %h", bus.flt_img, ei);
      end
    end
    n_cmp++;
    if (bus.err !== err_exp) begin
      n_bad++;
      $display("FAIL err: got %b, expected %b", bus.err, err_exp);
    end
    if (auto_res) begin
      bus.flt_res_val = pipe[LAT-1];
      pipe = {pipe[LAT-2:0], bus.flt_val};
    end
  endtask
  task automatic clear_model();
    ker_q.delete();
    img_q.delete();
    m = 0;
    err_exp = 0;
    auto_res = 0;
    pipe = '0;
  endtask
  task automatic do_reset();
    bus.load_start = 0;
    bus.ker_val = 0;
    bus.ker_data = '0;
    bus.img_val = 0;
    bus.img_data = '0;
    bus.flt_res_val = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    clear_model();
  endtask
  task automatic feed_words(input int base, input int cnt, output int nval);
    nval = 0;
    for (int w = 0; w < cnt; w++) begin
      bus.ker_val = 1;
      bus.ker_data = KW'(base + w);
      tick();
      if (bus.cfg_val) nval++;
    end
    bus.ker_val = 0;
  endtask
  task automatic start_load();
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.cfg_val, bus.flt_val, bus.ker_rdy, bus.img_rdy, bus.loaded, bus.busy, bus.err} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, expected 0000000",
               {bus.cfg_val, bus.flt_val, bus.ker_rdy, bus.img_rdy, bus.loaded, bus.busy, bus.err});
    end
    n_cmp++;
    if (bus.cfg_ker !== '0 || bus.flt_img !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got cfg_ker=%0d flt_img=%h, expected 0/0", bus.cfg_ker, bus.flt_img);
    end
  endtask
  task automatic test_load();
    int nv, extra;
    start_load();
    n_cmp++;
    if (bus.ker_rdy !== 1'b1 || bus.busy !== 1'b1 || bus.loaded !== 1'b0) begin
      n_bad++;
      $display("FAIL load_enter: got rdy=%b busy=%b loaded=%b, expected 1/1/0", bus.ker_rdy, bus.busy, bus.loaded);
    end
    feed_words(1, 9, nv);
    tick();
    extra = bus.cfg_val ? 1 : 0;
    n_cmp++;
    if (nv + extra !== 9) begin
      n_bad++;
      $display("FAIL load_cfg_cycles: got %0d, expected 9", nv + extra);
    end
    n_cmp++;
    if (bus.loaded !== 1'b1 || bus.ker_rdy !== 1'b0 || bus.busy !== 1'b0 || bus.img_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_done: got loaded=%b ker_rdy=%b busy=%b img_rdy=%b, expected 1/0/0/1",
               bus.loaded, bus.ker_rdy, bus.busy, bus.img_rdy);
    end
  endtask
  task automatic test_stream();
    int sent = 0, nflt = 0;
    auto_res = 1;
    pipe = '0;
    for (int i = 0; i < 100 && sent < 20; i++) begin
      bus.img_val = (i % 2 == 0) || (i % 5 == 3);
      bus.img_data = (HN*IW)'($urandom);
      if (bus.img_val && bus.img_rdy) sent++;
      tick();
      if (bus.flt_val) nflt++;
    end
    bus.img_val = 0;
    for (int i = 0; i < 60 && (m != 0 || pipe != '0); i++) begin
      tick();
      if (bus.flt_val) nflt++;
    end
    auto_res = 0;
    bus.flt_res_val = 0;
    n_cmp++;
    if (nflt !== 20) begin
      n_bad++;
      $display("FAIL stream_count: got %0d flt_val cycles, expected 20", nflt);
    end
  endtask
  task automatic test_drain_reload();
    int nv;
    for (int i = 0; i < 12; i++) begin
      bus.img_val = 1;
      bus.img_data = (HN*IW)'($urandom);
      bus.load_start = (i == 11);
      tick();
    end
    bus.load_start = 0;
    n_cmp++;
    if (bus.img_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_pending: got img_rdy=%b busy=%b, expected 0/0", bus.img_rdy, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.ker_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_enter: got busy=%b ker_rdy=%b, expected 1/0", bus.busy, bus.ker_rdy);
    end
    for (int r = 0; r < 12; r++) begin
      bus.flt_res_val = 1;
      tick();
      n_cmp++;
      if (bus.ker_rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL drain_hold: after result %0d got ker_rdy=%b, expected 0", r + 1, bus.ker_rdy);
      end
    end
    bus.flt_res_val = 0;
    tick();
    n_cmp++;
    if (bus.ker_rdy !== 1'b1 || bus.loaded !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_to_load: got ker_rdy=%b loaded=%b busy=%b, expected 1/0/1", bus.ker_rdy, bus.loaded, bus.busy);
    end
    feed_words(100, 9, nv);
    bus.img_val = 0;
    tick();
    n_cmp++;
    if (bus.loaded !== 1'b1 || bus.img_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL reload_done: got loaded=%b img_rdy=%b, expected 1/1", bus.loaded, bus.img_rdy);
    end
  endtask
  task automatic test_inflight_edges();
    int nv;
    bus.img_val = 1;
    bus.img_data = (HN*IW)'($urandom);
    tick();
    bus.img_val = 0;
    tick();
    bus.img_val = 1;
    bus.img_data = (HN*IW)'($urandom);
    tick();
    bus.img_val = 0;
    bus.flt_res_val = 1;
    tick();
    tick();
    bus.flt_res_val = 0;
    start_load();
    tick();
    tick();
    n_cmp++;
    if (bus.ker_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle_inflight: got ker_rdy=%b after drain, expected 1", bus.ker_rdy);
    end
    bus.flt_res_val = 1;
    tick();
    bus.flt_res_val = 0;
    repeat (3) tick();
    n_cmp++;
    if (bus.err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b, expected 1", bus.err);
    end
    feed_words(200, 9, nv);
    tick();
  endtask
  task automatic test_reset_midload();
    int nv;
    start_load();
    tick();
    tick();
    feed_words(300, 4, nv);
    rst_n = 0;
    #1;
    n_cmp++;
    if ({bus.cfg_val, bus.ker_rdy, bus.busy, bus.loaded, bus.err, bus.flt_val} !== 6'b0 || bus.cfg_ker !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got flags=%b cfg_ker=%0d, expected 000000/0",
               {bus.cfg_val, bus.ker_rdy, bus.busy, bus.loaded, bus.err, bus.flt_val}, bus.cfg_ker);
    end
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.ker_rdy !== 1'b0 || bus.img_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b ker_rdy=%b img_rdy=%b, expected 0/0/0", bus.busy, bus.ker_rdy, bus.img_rdy);
    end
    start_load();
    feed_words(400, 8, nv);
    n_cmp++;
    if (bus.loaded !== 1'b0 || bus.ker_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL fresh_load_8: got loaded=%b ker_rdy=%b, expected 0/1", bus.loaded, bus.ker_rdy);
    end
    feed_words(408, 1, nv);
    n_cmp++;
    if (bus.loaded !== 1'b1 || bus.ker_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL fresh_load_9: got loaded=%b ker_rdy=%b, expected 1/0", bus.loaded, bus.ker_rdy);
    end
  endtask
  task automatic test_wrong_state();
    int nv;
    bus.ker_val = 1;
    bus.ker_data = 16'hBEEF;
    repeat (3) tick();
    do_reset();
    bus.ker_val = 1;
    bus.ker_data = 16'hDEAD;
    repeat (3) tick();
    bus.ker_val = 0;
    n_cmp++;
    if (bus.ker_rdy !== 1'b0 || bus.loaded !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ker: got ker_rdy=%b loaded=%b, expected 0/0", bus.ker_rdy, bus.loaded);
    end
    start_load();
    bus.img_val = 1;
    bus.img_data = 24'hA5A5A5;
    feed_words(500, 9, nv);
    bus.img_val = 0;
    n_cmp++;
    if (bus.loaded !== 1'b1 || bus.flt_img !== '0) begin
      n_bad++;
      $display("FAIL load_img_blocked: got loaded=%b flt_img=%h, expected 1/000000", bus.loaded, bus.flt_img);
    end
  endtask
  initial begin
    rst_n = 1;
    test_reset();
    test_load();
    test_stream();
    test_drain_reload();
    test_inflight_edges();
    test_reset_midload();
    test_wrong_state();
    n_cmp++;
    if (ker_q.size() != 0 || img_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d ker / %0d img pending, expected 0/0", ker_q.size(), img_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
